// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS core: datapath width,
// next-PC select codes and the opcodes the control FSM decodes.
package mips_pkg;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned PCSRC_W  = 2;

  localparam logic [PCSRC_W-1:0] PCSRC_SEQ = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_BR  = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JMP = 2'b10;
  localparam logic [PCSRC_W-1:0] PCSRC_RSV = 2'b11;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // Jump target: upper nibble of the already-incremented PC, 26-bit word index.
  function automatic logic [WIDTH-1:0] jump_target(input logic [WIDTH-1:0] pc_plus4,
                                                   input logic [WIDTH-1:0] ir);
    return {pc_plus4[31:28], ir[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_en_reg.sv
// Parameterised-width register with load enable and async active-low clear.
module en_reg #(
  parameter int unsigned   W       = 32,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC / IR / MDR / ALUOut register stage of the multicycle MIPS core,
// including branch resolution and next-PC selection.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH    = mips_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCWrite,
  input  logic               BeQ,
  input  logic               BnE,
  input  logic [PCSRC_W-1:0] PCSrc,
  input  logic               IRWrite,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic [WIDTH-1:0]   pc,
  output logic [WIDTH-1:0]   instr,
  output logic [OP_W-1:0]    op,
  output logic [WIDTH-1:0]   mdr,
  output logic [WIDTH-1:0]   alu_out,
  output logic               pc_en,
  output logic [31:0]        instr_count
);

  logic [WIDTH-1:0] next_pc_c;
  logic             pc_load_c;
  logic [31:0]      count_inc_c;

  assign pc_en = PCWrite | (BeQ & alu_zero) | (BnE & ~alu_zero);

  // Reserved select freezes the PC even with the enable asserted.
  always_comb begin
    next_pc_c = pc;
    pc_load_c = pc_en;
    unique case (PCSrc)
      PCSRC_SEQ: next_pc_c = alu_result;
      PCSRC_BR:  next_pc_c = alu_out;
      PCSRC_JMP: next_pc_c = jump_target(pc, instr);
      default:   pc_load_c = 1'b0;
    endcase
  end

  assign count_inc_c = instr_count + 32'd1;
  assign op          = instr[31:26];

  en_reg #(.W(WIDTH), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst), .en(pc_load_c), .d(next_pc_c), .q(pc)
  );

  en_reg #(.W(WIDTH), .RST_VAL('0)) u_instr (
    .clk(clk), .rst_n(rst), .en(IRWrite), .d(mem_rdata), .q(instr)
  );

  en_reg #(.W(WIDTH), .RST_VAL('0)) u_mdr (
    .clk(clk), .rst_n(rst), .en(1'b1), .d(mem_rdata), .q(mdr)
  );

  en_reg #(.W(WIDTH), .RST_VAL('0)) u_alu_out (
    .clk(clk), .rst_n(rst), .en(1'b1), .d(alu_result), .q(alu_out)
  );

  en_reg #(.W(32), .RST_VAL('0)) u_count (
    .clk(clk), .rst_n(rst), .en(IRWrite), .d(count_inc_c), .q(instr_count)
  );

endmodule
